// File: rtl/park_pkg.sv
// rtl/park_pkg.sv - shared constants, FSM states and Q1.15 round/saturate for the Park MAC
package park_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 15;
    localparam int ACC_W  = 2 * DATA_W + 1;

    localparam logic signed [DATA_W-1:0] Q15_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Q15_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P0,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_RND,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] val;
        logic                     sat;
    } rnd_t;

    // Round half up by adding 2^(FRAC_W-1), then arithmetic shift at full accumulator width.
    function automatic rnd_t round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        rnd_t                    res;
        bias           = '0;
        bias[FRAC_W-1] = 1'b1;
        r  = (acc + bias) >>> FRAC_W;
        hi = {{(ACC_W-DATA_W){Q15_MAX[DATA_W-1]}}, Q15_MAX};
        lo = {{(ACC_W-DATA_W){Q15_MIN[DATA_W-1]}}, Q15_MIN};
        if (r > hi) begin
            res.val = Q15_MAX;
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.val = Q15_MIN;
            res.sat = 1'b1;
        end else begin
            res.val = r[DATA_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/park_direct_mac_seq_if.sv
// rtl/park_direct_mac_seq_if.sv - operand/result handshake bundle for the Park MAC
interface park_direct_mac_seq_if;
    import park_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] i_alpha;
    logic signed [DATA_W-1:0] i_beta;
    logic signed [DATA_W-1:0] sin_th;
    logic signed [DATA_W-1:0] cos_th;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] i_d;
    logic signed [DATA_W-1:0] i_q;
    logic [1:0]               out_sat;
    logic                     busy;

    modport master (
        output in_valid, i_alpha, i_beta, sin_th, cos_th, out_ready,
        input  in_ready, out_valid, i_d, i_q, out_sat, busy
    );

    modport slave (
        input  in_valid, i_alpha, i_beta, sin_th, cos_th, out_ready,
        output in_ready, out_valid, i_d, i_q, out_sat, busy
    );

endinterface

// File: rtl/park_mac_mul.sv
// rtl/park_mac_mul.sv - combinational signed DATA_W x DATA_W multiplier
module park_mac_mul
    import park_pkg::*;
(
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/park_direct_mac_seq.sv
// rtl/park_direct_mac_seq.sv - Park direct transform, one shared multiplier, one product per cycle
module park_direct_mac_seq
    import park_pkg::*;
(
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    park_direct_mac_seq_if.slave bus
);

    state_t state;
    state_t state_nxt;

    logic signed [DATA_W-1:0]   op_a;
    logic signed [DATA_W-1:0]   op_b;
    logic signed [DATA_W-1:0]   op_s;
    logic signed [DATA_W-1:0]   op_c;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [DATA_W-1:0]   mul_x;
    logic signed [DATA_W-1:0]   mul_y;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    rnd_t                       rnd_d;
    rnd_t                       rnd_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = ST_P0;
            ST_P0:   state_nxt = ST_P1;
            ST_P1:   state_nxt = ST_P2;
            ST_P2:   state_nxt = ST_P3;
            ST_P3:   state_nxt = ST_RND;
            ST_RND:  state_nxt = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_OUT);
        bus.busy      = (state != ST_IDLE);
    end

    // Operand pairing per product slot: (a,c) (b,s) (b,c) (a,s).
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            ST_P0: begin mul_x = op_a; mul_y = op_c; end
            ST_P1: begin mul_x = op_b; mul_y = op_s; end
            ST_P2: begin mul_x = op_b; mul_y = op_c; end
            ST_P3: begin mul_x = op_a; mul_y = op_s; end
            default: begin mul_x = '0; mul_y = '0; end
        endcase
    end

    park_mac_mul u_mul (
        .a (mul_x),
        .b (mul_y),
        .p (prod)
    );

    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign rnd_d    = round_sat(acc_d);
    assign rnd_q    = round_sat(acc_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            op_s        <= '0;
            op_c        <= '0;
            acc_d       <= '0;
            acc_q       <= '0;
            bus.i_d     <= '0;
            bus.i_q     <= '0;
            bus.out_sat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_a <= bus.i_alpha;
                        op_b <= bus.i_beta;
                        op_s <= bus.sin_th;
                        op_c <= bus.cos_th;
                    end
                end
                ST_P0:  acc_d <= prod_ext;
                ST_P1:  acc_d <= acc_d + prod_ext;
                ST_P2:  acc_q <= prod_ext;
                ST_P3:  acc_q <= acc_q - prod_ext;
                ST_RND: begin
                    bus.i_d     <= rnd_d.val;
                    bus.i_q     <= rnd_q.val;
                    bus.out_sat <= {rnd_q.sat, rnd_d.sat};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_park_direct_mac_seq.sv
// tb/tb_park_direct_mac_seq.sv - self-checking bench for park_direct_mac_seq
module tb_park_direct_mac_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    park_direct_mac_seq_if bus();

    park_direct_mac_seq dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int s;
        int c;
        int ed;
        int eq;
        int esat;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void q15_round(input longint x, output int v, output int sat);
        longint r;
        r = (x + 16384) >>> 15;
        if (r > 32767) begin
            v = 32767; sat = 1;
        end else if (r < -32768) begin
            v = -32768; sat = 1;
        end else begin
            v = int'(r); sat = 0;
        end
    endfunction

    function automatic void model(input int a, input int b, input int s, input int c,
                                  output int d, output int q, output int sat);
        int sd;
        int sq;
        q15_round(longint'(a) * c + longint'(b) * s, d, sd);
        q15_round(longint'(b) * c - longint'(a) * s, q, sq);
        sat = sd + 2 * sq;
    endfunction

    // Returns at the falling edge just after the accept edge.
    task automatic start_set(input int a, input int b, input int s, input int c);
        int w;
        @(negedge clk);
        bus.i_alpha  = 16'(a);
        bus.i_beta   = 16'(b);
        bus.sin_th   = 16'(s);
        bus.cos_th   = 16'(c);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", longint'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_set(input int a, input int b, input int s, input int c, input bit hold_ready,
                           output int d, output int q, output int sat, output int edges);
        bus.out_ready = hold_ready;
        start_set(a, b, s, c);
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        d   = int'(bus.i_d);
        q   = int'(bus.i_q);
        sat = int'(bus.out_sat);
        if (!hold_ready) bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_drop", longint'(bus.out_valid), 0);
        chk("idle_after", longint'(bus.busy), 0);
    endtask

    initial begin
        int d, q, sat, edges;
        int ed, eq, es;
        int a, b, s, c;
        bit seen;

        tbl[0] = '{a: 1000,   b: 2000,   s: 0,      c: 32767,  ed: 1000,   eq: 2000,  esat: 0};
        tbl[1] = '{a: 1000,   b: 2000,   s: 32767,  c: 0,      ed: 2000,   eq: -1000, esat: 0};
        tbl[2] = '{a: 10000,  b: 10000,  s: 23170,  c: 23170,  ed: 14142,  eq: 0,     esat: 0};
        tbl[3] = '{a: -32768, b: -32768, s: -32768, c: -32768, ed: 32767,  eq: 0,     esat: 1};
        tbl[4] = '{a: -32768, b: -32768, s: 32767,  c: 32767,  ed: -32768, eq: 0,     esat: 1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.i_alpha   = '0;
        bus.i_beta    = '0;
        bus.sin_th    = '0;
        bus.cos_th    = '0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_busy",      longint'(bus.busy), 0);
        chk("rst_i_d",       longint'(bus.i_d), 0);
        chk("rst_i_q",       longint'(bus.i_q), 0);
        chk("rst_out_sat",   longint'(bus.out_sat), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_set(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, 1'b0, d, q, sat, edges);
            chk($sformatf("tbl%0d_latency", i), edges, 6);
            chk($sformatf("tbl%0d_i_d", i), d, tbl[i].ed);
            chk($sformatf("tbl%0d_i_q", i), q, tbl[i].eq);
            chk($sformatf("tbl%0d_sat", i), sat, tbl[i].esat);
        end

        for (int n = 0; n < 40; n++) begin
            a = ($urandom % 8 == 0) ? -32768 : $signed(16'($urandom));
            b = ($urandom % 8 == 0) ? 32767  : $signed(16'($urandom));
            s = ($urandom % 8 == 0) ? -32768 : $signed(16'($urandom));
            c = ($urandom % 8 == 0) ? 32767  : $signed(16'($urandom));
            model(a, b, s, c, ed, eq, es);
            run_set(a, b, s, c, 1'($urandom % 2), d, q, sat, edges);
            chk($sformatf("rnd%0d_latency", n), edges, 6);
            chk($sformatf("rnd%0d_i_d", n), d, ed);
            chk($sformatf("rnd%0d_i_q", n), q, eq);
            chk($sformatf("rnd%0d_sat", n), sat, es);
        end

        // Backpressure: result held while new operands are offered and ignored.
        bus.out_ready = 1'b0;
        start_set(1000, 2000, 0, 32767);
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("bp_latency", edges, 6);
        bus.i_alpha  = 16'(-5000);
        bus.i_beta   = 16'(7000);
        bus.sin_th   = 16'(12345);
        bus.cos_th   = 16'(-2222);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp%0d_valid", k), longint'(bus.out_valid), 1);
            chk($sformatf("bp%0d_in_ready", k), longint'(bus.in_ready), 0);
            chk($sformatf("bp%0d_i_d", k), longint'(bus.i_d), 1000);
            chk($sformatf("bp%0d_i_q", k), longint'(bus.i_q), 2000);
            chk($sformatf("bp%0d_sat", k), longint'(bus.out_sat), 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_valid", longint'(bus.out_valid), 0);
        chk("bp_release_busy",  longint'(bus.busy), 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        chk("bp_no_extra", longint'(seen), 0);

        // Reset while the third product slot is active.
        start_set(3000, -4000, 20000, 15000);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", longint'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  longint'(bus.in_ready), 1);
        chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
        chk("mid_rst_busy",      longint'(bus.busy), 0);
        chk("mid_rst_i_d",       longint'(bus.i_d), 0);
        chk("mid_rst_i_q",       longint'(bus.i_q), 0);
        chk("mid_rst_sat",       longint'(bus.out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", longint'(seen), 0);

        run_set(-1000, 3000, 16384, 16384, 1'b1, d, q, sat, edges);
        model(-1000, 3000, 16384, 16384, ed, eq, es);
        chk("recover_latency", edges, 6);
        chk("recover_i_d", d, ed);
        chk("recover_i_q", q, eq);
        chk("recover_sat", sat, es);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/park_direct_mac_seq.md
Name: park_direct_mac_seq

Overview:
- Time-multiplexed Park direct transform for the FOC current path.
- Takes Clarke outputs (i_alpha, i_beta) plus sin/cos of the rotor angle, all Q1.15.
- Produces i_d = i_alpha·cos + i_beta·sin and i_q = i_beta·cos − i_alpha·sin through one shared 16x16 signed multiplier, one product per cycle.
- Sits between the Clarke stage and the d/q PI controllers; valid/ready on both sides.

Parameters:
- DATA_W, 16, width of all operands and results (signed).
- FRAC_W, 15, fractional bits of sin/cos; product shift amount.
- ACC_W, 2*DATA_W+1, accumulator width (holds sum of two full products without overflow).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- i_alpha  in  DATA_W  alpha current, signed.
- i_beta  in  DATA_W  beta current, signed.
- sin_th  in  DATA_W  sin(theta), signed Q1.15.
- cos_th  in  DATA_W  cos(theta), signed Q1.15.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- i_d  out  DATA_W  d-axis current, signed.
- i_q  out  DATA_W  q-axis current, signed.
- out_sat  out  2  bit0 = i_d saturated, bit1 = i_q saturated; valid with out_valid.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Interface decision: single clock ap_clk; reset ap_rst_n is asynchronous, active low.
- Reset values: state IDLE, in_ready=1, out_valid=0, i_d=0, i_q=0, out_sat=0, busy=0, accumulators and operand latches 0.
- FSM: IDLE -> P0 -> P1 -> P2 -> P3 -> RND -> OUT -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch all four operands and go to P0. Operands are ignored in every other state.
- P0: acc_d <= a·c (assign, not add).
- P1: acc_d <= acc_d + b·s.
- P2: acc_q <= b·c.
- P3: acc_q <= acc_q − a·s.
- The product is the combinational output of the shared multiplier. Operand mux selects (a,c), (b,s), (b,c), (a,s) per state.
- RND: each accumulator: r = (acc + 2^(FRAC_W−1)) >>> FRAC_W, arithmetic shift, computed at ACC_W bits.
  - r > 32767 -> 32767, sat bit = 1.
  - r < −32768 -> −32768, sat bit = 1.
  - otherwise truncate to DATA_W, sat bit = 0.
  - Load i_d, i_q, out_sat registers; next state OUT.
- OUT: out_valid=1. i_d, i_q and out_sat are held stable until out_valid&&out_ready, then IDLE with out_valid=0 on the next cycle.
- No input acceptance in OUT. Minimum throughput is one set per 7 cycles.
- Latency: out_valid rises 6 clock edges after the accept edge (P0, P1, P2, P3, RND, OUT entry), i.e. 5 cycles between accept and first out_valid=1 cycle.
- i_d, i_q and out_sat change only on the RND->OUT edge or on reset.
- Async reset mid-operation: immediate return to reset values. The in-flight set is discarded and no result is produced.
- out_ready held high continuously: still one result per operand set, never duplicated.
- All multiply and accumulate is signed two's complement. −32768·−32768 = 2^30 must be represented exactly (ACC_W ≥ 33).

Decomposition:
- Shared package park_pkg: DATA_W and FRAC_W constants, Q1.15 limit constants (Q15_MAX=32767, Q15_MIN=−32768), and the FSM state enum.
- One sub-module, park_mac_mul: pure combinational DATA_W x DATA_W signed multiply, 2·DATA_W result, DSP-mappable.
- Rounding/saturation is a function in park_pkg, not a module.

Test Plan:
- i_alpha=1000, i_beta=2000, cos=32767, sin=0 -> i_d=1000, i_q=2000, out_sat=0. out_valid rises 6 edges after accept.
- i_alpha=1000, i_beta=2000, cos=0, sin=32767 -> i_d=2000, i_q=−1000, out_sat=0.
- i_alpha=i_beta=10000, cos=sin=23170 -> i_d=14142, i_q=0.
- Saturation positive: all four inputs = −32768 -> i_d=32767, i_q=0, out_sat=2'b01.
- Saturation negative: i_alpha=i_beta=−32768, cos=sin=32767 -> i_d=−32768, i_q=0, out_sat=2'b01.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0, new in_valid ignored. Release: one handshake, then IDLE.
  - Assert ap_rst_n=0 during P2: all outputs at reset values at once, no out_valid after release.
